// File: rtl/fp_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_scheduler
// Purpose  : Sequences a fixed-latency FP multiply beside ID/EX, stalls ID on
//            hazards against its pending destination, arbitrates the FPR port.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_scheduler #(
  parameter int MULT_LATENCY = 5,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_id_valid,
  input  logic        i_id_is_mult,
  input  logic [4:0]  i_id_Rs,
  input  logic [4:0]  i_id_Rt,
  input  logic [4:0]  i_id_Rw,
  input  logic [31:0] i_mult_result,
  input  logic        i_pipe_wb_we,
  input  logic [4:0]  i_pipe_wb_Rw,
  input  logic [31:0] i_pipe_wb_data,
  output logic        o_mult_start,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_Rw,
  output logic [31:0] o_rf_busW,
  output logic        o_Stall_ID,
  output logic        o_mult_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]  r_pend_Rw;
  logic [31:0] r_buf;

  logic        w_busy;
  logic        w_issue;
  logic        w_done;
  logic        w_mult_wr;
  logic [31:0] w_mult_data;

  assign w_busy = (r_state != S_IDLE);
  assign w_done = (r_state == S_BUSY) && (r_cnt == '0);

  // F0 is an ordinary register here, so no zero-register exemption.
  assign o_Stall_ID = i_id_valid & w_busy &
                      (i_id_is_mult | (i_id_Rs == r_pend_Rw) |
                       (i_id_Rt == r_pend_Rw) | (i_id_Rw == r_pend_Rw));

  assign w_issue = !reset && (r_state == S_IDLE) && i_id_valid &&
                   i_id_is_mult && !o_Stall_ID;

  assign o_mult_start = w_issue;
  assign o_mult_busy  = w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_mult_wr   = 1'b0;
    w_mult_data = r_buf;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_done) begin
          if (i_pipe_wb_we) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
            w_mult_wr   = 1'b1;
            w_mult_data = i_mult_result;
          end
        end
      end
      S_HOLD: begin
        if (!i_pipe_wb_we) begin
          w_state_nxt = S_IDLE;
          w_mult_wr   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pipeline writeback always owns the port; a reset cycle never commits a multiply.
  always_comb begin
    o_rf_we   = 1'b0;
    o_rf_Rw   = 5'd0;
    o_rf_busW = 32'd0;
    if (i_pipe_wb_we) begin
      o_rf_we   = 1'b1;
      o_rf_Rw   = i_pipe_wb_Rw;
      o_rf_busW = i_pipe_wb_data;
    end else if (w_mult_wr && !reset) begin
      o_rf_we   = 1'b1;
      o_rf_Rw   = r_pend_Rw;
      o_rf_busW = w_mult_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend_Rw <= 5'd0;
      r_buf     <= 32'd0;
    end else begin
      if (w_issue) begin
        r_cnt     <= C_CNT_LOAD;
        r_pend_Rw <= i_id_Rw;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && i_pipe_wb_we) r_buf <= i_mult_result;
    end
  end

endmodule
`default_nettype wire
